// File: rtl/nq_pkg.sv
// Shared NanoQuarter definitions: opcode/funct encodings, stage state encoding
// and default widths.
package nq_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 16;

  // {op, funct} encodings as produced by the ALU stage.
  typedef logic [4:0] opf_t;
  localparam opf_t OPF_NAND = 5'b00_000;
  localparam opf_t OPF_ADD  = 5'b00_101;
  localparam opf_t OPF_SUB  = 5'b00_110;
  localparam opf_t OPF_XOR  = 5'b00_111;
  localparam opf_t OPF_LW   = 5'b01_100;
  localparam opf_t OPF_SW   = 5'b01_101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MEM  = 1'b1
  } state_t;

  function automatic logic is_mem_op(input logic [1:0] op, input logic [2:0] funct);
    return ({op, funct} == OPF_LW) || ({op, funct} == OPF_SW);
  endfunction

endpackage

// File: rtl/nq_mem_fsm.sv
// Request/acknowledge state machine for the memory stage. The optional watchdog
// counter is built only when MEM_TIMEOUT_EN is defined.
module nq_mem_fsm
  import nq_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic ack,
  output logic busy,
  output logic done,
  output logic expire,
  output logic err
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("nq_mem_fsm: TIMEOUT must be at least 1");
  end

  state_t state;

  // mem_req is this flop directly, so it is glitch-free and registered.
  assign busy = (state == ST_MEM);
  // An ack outside the MEM state never completes anything.
  assign done = busy && ack;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt;

  // cnt holds (request cycles so far - 1); an ack on the last cycle still wins.
  assign expire = busy && !ack && (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= '0;
    end else if (busy) begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  assign expire = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      err   <= 1'b0;
    end else begin
      err <= expire;
      case (state)
        ST_IDLE: if (start)           state <= ST_MEM;
        ST_MEM:  if (done || expire)  state <= ST_IDLE;
        default:                      state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mem_stage.sv
// NanoQuarter memory stage: pipeline registers, LW/SW request outputs and the
// writeback mux. Define MEM_TIMEOUT_EN to enable the request watchdog.
module mem_stage
  import nq_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int RD_W    = 3,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [1:0]        ex_op,
  input  logic [2:0]        ex_funct,
  input  logic [DATA_W-1:0] ex_aluout,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [RD_W-1:0]   ex_rd,
  input  logic              ex_wen,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              wb_valid,
  output logic              wb_wen,
  output logic [RD_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              mem_err
);

  logic busy, done, expire, accept, mem_op;
  logic [RD_W-1:0] pend_rd;
  logic            pend_wen;

  assign ex_ready = !busy;
  assign mem_req  = busy;
  assign accept   = ex_valid && ex_ready;
  assign mem_op   = is_mem_op(ex_op, ex_funct);

  nq_mem_fsm #(.TIMEOUT(TIMEOUT)) u_fsm (
    .clk    (clk),
    .rst    (rst),
    .start  (accept && mem_op),
    .ack    (mem_ack),
    .busy   (busy),
    .done   (done),
    .expire (expire),
    .err    (mem_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      pend_rd   <= '0;
      pend_wen  <= 1'b0;
      wb_valid  <= 1'b0;
      wb_wen    <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
    end else begin
      wb_valid <= 1'b0;
      wb_wen   <= 1'b0;
      if (accept && !mem_op) begin
        wb_valid <= 1'b1;
        wb_wen   <= ex_wen;
        wb_rd    <= ex_rd;
        wb_data  <= ex_aluout;
      end else if (accept) begin
        mem_we    <= ({ex_op, ex_funct} == OPF_SW);
        mem_addr  <= ex_addr;
        mem_wdata <= ex_aluout;
        pend_rd   <= ex_rd;
        pend_wen  <= ex_wen;
      end
      // Request registers are only reloaded on accept, so they stay stable
      // for the whole MEM residency.
      if (done) begin
        wb_valid <= 1'b1;
        wb_wen   <= pend_wen && !mem_we;
        wb_rd    <= pend_rd;
        wb_data  <= mem_we ? mem_wdata : mem_rdata;
      end else if (expire) begin
        wb_valid <= 1'b1;
        wb_wen   <= 1'b0;
        wb_rd    <= pend_rd;
        wb_data  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage; the timeout scenario runs when MEM_TIMEOUT_EN
// is defined, otherwise an indefinite-wait scenario runs instead.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic [1:0]  ex_op;
  logic [2:0]  ex_funct;
  logic [15:0] ex_aluout;
  logic [15:0] ex_addr;
  logic [2:0]  ex_rd;
  logic        ex_wen;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        wb_valid;
  logic        wb_wen;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;
  logic        mem_err;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  mem_stage #(.DATA_W(16), .ADDR_W(16), .RD_W(3), .TIMEOUT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .ex_valid  (ex_valid),
    .ex_ready  (ex_ready),
    .ex_op     (ex_op),
    .ex_funct  (ex_funct),
    .ex_aluout (ex_aluout),
    .ex_addr   (ex_addr),
    .ex_rd     (ex_rd),
    .ex_wen    (ex_wen),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .wb_valid  (wb_valid),
    .wb_wen    (wb_wen),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .mem_err   (mem_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [2:0] funct, input logic [15:0] alu,
                       input logic [15:0] addr, input logic [2:0] rd, input logic wen);
    ex_valid  = 1'b1;
    ex_op     = op;
    ex_funct  = funct;
    ex_aluout = alu;
    ex_addr   = addr;
    ex_rd     = rd;
    ex_wen    = wen;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int stall;
    int idx;
    int reqc;
    int bad;
    logic acc;
    logic [15:0] got[$];

    rst = 1'b1; ex_valid = 1'b0; ex_op = '0; ex_funct = '0; ex_aluout = '0;
    ex_addr = '0; ex_rd = '0; ex_wen = 1'b0; mem_rdata = '0; mem_ack = 1'b0;
    step(); step();
    check("rst_mem_req",  mem_req,  0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_data",  wb_data,  0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_err",  mem_err,  0);
    check("rst_ex_ready", ex_ready, 1);
    rst = 1'b0;
    step();

    // ADD passthrough, latency 1
    drive(2'b00, 3'b101, 16'h1234, 16'h0000, 3'd3, 1'b1);
    step();
    ex_valid = 1'b0;
    check("add_wb_valid", wb_valid, 1);
    check("add_wb_data",  wb_data,  16'h1234);
    check("add_wb_rd",    wb_rd,    3);
    check("add_wb_wen",   wb_wen,   1);
    check("add_ex_ready", ex_ready, 1);
    step();
    check("add_wb_pulse", wb_valid, 0);

    // Undefined {op,funct} behaves as passthrough
    drive(2'b11, 3'b111, 16'h0F0F, 16'h0040, 3'd1, 1'b0);
    step();
    ex_valid = 1'b0;
    check("undef_wb_valid", wb_valid, 1);
    check("undef_wb_data",  wb_data,  16'h0F0F);
    check("undef_mem_req",  mem_req,  0);

    // LW, ack on third request cycle
    drive(2'b01, 3'b100, 16'h7777, 16'h0040, 3'd5, 1'b1);
    step();
    ex_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("lw_mem_req",  mem_req,  1);
      check("lw_mem_addr", mem_addr, 16'h0040);
      check("lw_mem_we",   mem_we,   0);
      check("lw_ex_ready", ex_ready, 0);
      check("lw_wb_quiet", wb_valid, 0);
      if (i == 2) begin mem_ack = 1'b1; mem_rdata = 16'hBEEF; end
      step();
    end
    mem_ack = 1'b0; mem_rdata = '0;
    check("lw_req_drop", mem_req,  0);
    check("lw_wb_valid", wb_valid, 1);
    check("lw_wb_data",  wb_data,  16'hBEEF);
    check("lw_wb_rd",    wb_rd,    5);
    check("lw_wb_wen",   wb_wen,   1);
    check("lw_ex_ready", ex_ready, 1);
    step();

    // SW, ack in the first request cycle
    drive(2'b01, 3'b101, 16'hA5A5, 16'h0010, 3'd2, 1'b1);
    step();
    ex_valid = 1'b0;
    mem_ack  = 1'b1;
    check("sw_mem_req",   mem_req,   1);
    check("sw_mem_we",    mem_we,    1);
    check("sw_mem_wdata", mem_wdata, 16'hA5A5);
    check("sw_mem_addr",  mem_addr,  16'h0010);
    step();
    mem_ack = 1'b0;
    check("sw_req_drop", mem_req,  0);
    check("sw_wb_valid", wb_valid, 1);
    check("sw_wb_wen",   wb_wen,   0);
    check("sw_wb_data",  wb_data,  16'hA5A5);
    step();

    // SUB, LW, XOR back to back; XOR must wait for the LW
    idx = 0; reqc = 0; stall = 0;
    for (int c = 0; c < 20 && got.size() < 3; c++) begin
      case (idx)
        0: drive(2'b00, 3'b110, 16'h0011, 16'h0000, 3'd1, 1'b1);
        1: drive(2'b01, 3'b100, 16'h0000, 16'h0020, 3'd2, 1'b1);
        2: drive(2'b00, 3'b111, 16'h0033, 16'h0000, 3'd3, 1'b1);
        default: ex_valid = 1'b0;
      endcase
      reqc      = mem_req ? reqc + 1 : 0;
      mem_ack   = mem_req && (reqc == 2);
      mem_rdata = mem_ack ? 16'h2222 : 16'h0000;
      if (ex_valid && !ex_ready) stall++;
      acc = ex_valid && ex_ready;
      step();
      if (acc) idx++;
      if (wb_valid) got.push_back(wb_data);
    end
    ex_valid = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    check("b2b_beats", got.size(), 3);
    check("b2b_stall", stall, 2);
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      case (i)
        0: check("b2b_sub", got[i], 16'h0011);
        1: check("b2b_lw",  got[i], 16'h2222);
        default: check("b2b_xor", got[i], 16'h0033);
      endcase
    end
    step();

    // Reset on the second request cycle abandons the access
    drive(2'b01, 3'b100, 16'h0000, 16'h0044, 3'd4, 1'b1);
    step();
    ex_valid = 1'b0;
    step();
    check("rstm_req_before", mem_req, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstm_mem_req",  mem_req,  0);
    check("rstm_wb_valid", wb_valid, 0);
    check("rstm_ex_ready", ex_ready, 1);
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    step();
    mem_ack = 1'b0; mem_rdata = '0;
    check("late_ack_wb", wb_valid, 0);
    check("late_ack_req", mem_req, 0);
    step();

`ifdef MEM_TIMEOUT_EN
    // No ack: four request cycles, then error and a non-writing beat
    drive(2'b01, 3'b100, 16'h0000, 16'h0080, 3'd6, 1'b1);
    step();
    ex_valid = 1'b0;
    reqc = 0;
    for (int c = 0; c < 10 && mem_req; c++) begin
      reqc++;
      step();
    end
    check("tmo_req_cycles", reqc, 4);
    check("tmo_mem_err",    mem_err,  1);
    check("tmo_wb_valid",   wb_valid, 1);
    check("tmo_wb_wen",     wb_wen,   0);
    check("tmo_ex_ready",   ex_ready, 1);
    step();
    check("tmo_err_pulse",  mem_err,  0);
    check("tmo_wb_pulse",   wb_valid, 0);

    // Ack on the fourth cycle is a success
    drive(2'b01, 3'b100, 16'h0000, 16'h0084, 3'd6, 1'b1);
    step();
    ex_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("tmo_edge_req", mem_req, 1);
      if (i == 3) begin mem_ack = 1'b1; mem_rdata = 16'h5A5A; end
      step();
    end
    mem_ack = 1'b0; mem_rdata = '0;
    check("tmo_edge_err",  mem_err,  0);
    check("tmo_edge_wb",   wb_valid, 1);
    check("tmo_edge_data", wb_data,  16'h5A5A);
    check("tmo_edge_wen",  wb_wen,   1);
`else
    // Without the watchdog the request waits indefinitely
    drive(2'b01, 3'b100, 16'h0000, 16'h0080, 3'd6, 1'b1);
    step();
    ex_valid = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (!mem_req || mem_err || wb_valid) bad++;
      step();
    end
    check("wait_hold", bad, 0);
    mem_ack = 1'b1; mem_rdata = 16'h5A5A;
    step();
    mem_ack = 1'b0; mem_rdata = '0;
    check("wait_wb_valid", wb_valid, 1);
    check("wait_wb_data",  wb_data,  16'h5A5A);
    check("wait_mem_err",  mem_err,  0);
    check("wait_req_drop", mem_req,  0);
`endif
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
